// File: rtl/regfile_wb_arbiter.sv
// Write-back controller: round-robin arbitration of ALU and load results onto the
// register file's single write port, plus a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [AW-1:0]        mem_rd,
    input  logic [XLEN-1:0]      mem_data,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 we3,
    output logic [AW-1:0]        a3,
    output logic [XLEN-1:0]      wd3,
    output logic [(1<<AW)-1:0]   busy
);

    localparam int NREG = 1 << AW;
    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    logic              pri_q, pri_d;
    logic              we3_q, we3_d;
    logic [AW-1:0]     a3_q, a3_d;
    logic [XLEN-1:0]   wd3_q, wd3_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              alu_gnt, mem_gnt, xfer;
    logic [AW-1:0]     sel_rd;
    logic [XLEN-1:0]   sel_data;

    // Grants are suppressed during reset so no handshake can complete on a reset edge.
    always_comb begin
        alu_gnt = !reset && alu_valid && (!mem_valid || (pri_q == SRC_ALU));
        mem_gnt = !reset && mem_valid && (!alu_valid || (pri_q == SRC_MEM));
        xfer    = alu_gnt || mem_gnt;
    end

    always_comb begin
        sel_rd   = alu_gnt ? alu_rd   : mem_rd;
        sel_data = alu_gnt ? alu_data : mem_data;
    end

    always_comb begin
        pri_d = pri_q;
        if (xfer) begin
            pri_d = alu_gnt ? SRC_MEM : SRC_ALU;
        end
    end

    // A transfer to x0 completes the handshake but never reaches the write port.
    always_comb begin
        we3_d = xfer && (sel_rd != '0);
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (we3_d) begin
            a3_d  = sel_rd;
            wd3_d = sel_data;
        end
    end

    // Clear tracks the registered write port; the set is applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (we3_q) begin
            busy_d[a3_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q  <= SRC_ALU;
            we3_q  <= 1'b0;
            a3_q   <= '0;
            wd3_q  <= '0;
            busy_q <= '0;
        end else begin
            pri_q  <= pri_d;
            we3_q  <= we3_d;
            a3_q   <= a3_d;
            wd3_q  <= wd3_d;
            busy_q <= busy_d;
        end
    end

    assign alu_ready = alu_gnt;
    assign mem_ready = mem_gnt;
    assign we3       = we3_q;
    assign a3        = a3_q;
    assign wd3       = wd3_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table with a write-port
// scoreboard, then hand-written scoreboard, x0 and reset sequences.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_rd, mem_rd, issue_rd;
    logic [31:0] alu_data, mem_data;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .we3(we3), .a3(a3), .wd3(wd3), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register file model fed only by the DUT write port.
    logic [31:0] regs [32];
    always @(posedge clk) begin
        if (we3) regs[a3] <= wd3;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        ear;
        logic        emr;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } out_t;

    vec_t tbl [21];
    out_t sb [$];
    logic [4:0]  hold_a = '0;
    logic [31:0] hold_d = '0;

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                                logic mv, logic [4:0] mrd, logic [31:0] md,
                                logic ear, logic emr);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.ear = ear; v.emr = emr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic run_vec(input int idx);
        out_t e, nx;
        vec_t v;
        v = tbl[idx];
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.md;
        #1;
        chk($sformatf("alu_ready[%0d]", idx), alu_ready, v.ear);
        chk($sformatf("mem_ready[%0d]", idx), mem_ready, v.emr);
        if (sb.size() == 0) begin
            chk($sformatf("sb_empty[%0d]", idx), 1, 0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("we3[%0d]", idx), we3, e.we);
            chk($sformatf("a3[%0d]", idx), a3, e.a);
            chk($sformatf("wd3[%0d]", idx), wd3, e.d);
        end
        nx.we = 1'b0;
        if (v.ear && v.ard != 0) begin
            nx.we = 1'b1; hold_a = v.ard; hold_d = v.ad;
        end else if (v.emr && v.mrd != 0) begin
            nx.we = 1'b1; hold_a = v.mrd; hold_d = v.md;
        end
        nx.a = hold_a;
        nx.d = hold_d;
        sb.push_back(nx);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = '0;

        // Contention from reset: strict alternation ALU, MEM, ...
        tbl[0]  = mk(1, 1, 32'h10, 1, 11, 32'h20, 1, 0);
        tbl[1]  = mk(1, 2, 32'h11, 1, 11, 32'h20, 0, 1);
        tbl[2]  = mk(1, 2, 32'h11, 1, 12, 32'h21, 1, 0);
        tbl[3]  = mk(1, 3, 32'h12, 1, 12, 32'h21, 0, 1);
        tbl[4]  = mk(1, 3, 32'h12, 1, 13, 32'h22, 1, 0);
        tbl[5]  = mk(1, 4, 32'h13, 1, 13, 32'h22, 0, 1);
        tbl[6]  = mk(1, 4, 32'h13, 1, 14, 32'h23, 1, 0);
        tbl[7]  = mk(0, 0, 32'h0,  1, 14, 32'h23, 0, 1);
        tbl[8]  = mk(0, 0, 32'h0,  0, 0,  32'h0,  0, 0);
        tbl[9]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0, 1, 0);
        tbl[10] = mk(0, 0, 32'h0,  0, 0,  32'h0,  0, 0);
        tbl[11] = mk(0, 0, 32'h0,  0, 0,  32'h0,  0, 0);
        tbl[12] = mk(0, 0, 32'h0,  1, 0,  32'h55, 0, 1);
        tbl[13] = mk(0, 0, 32'h0,  0, 0,  32'h0,  0, 0);
        tbl[14] = mk(0, 0, 32'h0,  1, 9,  32'h99, 0, 1);
        tbl[15] = mk(1, 3, 32'h33, 0, 0,  32'h0,  1, 0);
        tbl[16] = mk(1, 6, 32'h66, 1, 8,  32'h88, 0, 1);
        tbl[17] = mk(1, 6, 32'h66, 0, 0,  32'h0,  1, 0);
        tbl[18] = mk(1, 20, 32'hA1, 1, 20, 32'hB2, 0, 1);
        tbl[19] = mk(1, 20, 32'hA1, 0, 0, 32'h0,  1, 0);
        tbl[20] = mk(0, 0, 32'h0,  0, 0,  32'h0,  0, 0);

        // Reset with requests present: no ready while reset is high
        idle_inputs();
        reset = 1'b1;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd3; mem_valid = 1'b1; mem_rd = 5'd4;
        #1;
        chk("rst_alu_ready", alu_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        tick();
        chk("rst_we3", we3, 0);
        chk("rst_a3", a3, 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_busy", busy, 0);
        idle_inputs();
        reset = 1'b0;

        sb.push_back('{we: 1'b0, a: 5'd0, d: 32'd0});
        for (int i = 0; i < 21; i++) run_vec(i);
        chk("tbl_busy", busy, 0);

        chk("rf1", regs[1], 32'h10);   chk("rf2", regs[2], 32'h11);
        chk("rf4", regs[4], 32'h13);   chk("rf11", regs[11], 32'h20);
        chk("rf12", regs[12], 32'h21); chk("rf13", regs[13], 32'h22);
        chk("rf14", regs[14], 32'h23); chk("rf5", regs[5], 32'hDEADBEEF);
        chk("rf3", regs[3], 32'h33);   chk("rf9", regs[9], 32'h99);
        chk("rf8", regs[8], 32'h88);   chk("rf6", regs[6], 32'h66);
        chk("rf20_order", regs[20], 32'hA1);
        chk("rf0", regs[0], 32'h0);

        // Busy set on issue, cleared on the edge that commits the write
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        chk("busy7_pre", busy[7], 0);
        tick();
        idle_inputs();
        chk("busy7_set", busy[7], 1);
        tick();
        chk("busy7_hold", busy[7], 1);
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        #1;
        chk("w7_ready", alu_ready, 1);
        tick();
        idle_inputs();
        chk("w7_we3", we3, 1);
        chk("w7_a3", a3, 7);
        chk("busy7_commit_cycle", busy[7], 1);
        tick();
        chk("busy7_cleared", busy[7], 0);
        chk("w7_we3_off", we3, 0);

        // Set and clear of the same register in one cycle: set wins
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle_inputs();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
        tick();
        idle_inputs();
        chk("sw_we3", we3, 1);
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle_inputs();
        chk("sw_busy7", busy[7], 1);
        tick();
        chk("sw_busy7_keep", busy[7], 1);

        // Issue to x0 never marks busy
        reset = 1'b1;
        tick();
        reset = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle_inputs();
        chk("x0_busy", busy, 0);

        // Reset while a write is held: it is dropped, pri returns to ALU
        issue_valid = 1'b1; issue_rd = 5'd10;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
        #1;
        chk("rd_ready", alu_ready, 1);
        tick();
        idle_inputs();
        reset = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'hCC;
        #1;
        chk("rd_pending_we3", we3, 1);
        chk("rd_alu_ready_rst", alu_ready, 0);
        chk("rd_mem_ready_rst", mem_ready, 0);
        tick();
        chk("rd_we3_dropped", we3, 0);
        chk("rd_busy_clear", busy, 0);
        reset = 1'b0;
        #1;
        chk("rd_pri_alu", alu_ready, 1);
        chk("rd_pri_mem", mem_ready, 0);
        tick();
        alu_valid = 1'b0;
        chk("rd_re_we3", we3, 1);
        chk("rd_re_a3", a3, 10);
        chk("rd_re_wd3", wd3, 32'hAA);
        #1;
        chk("rd_mem_next", mem_ready, 1);
        tick();
        idle_inputs();
        chk("rd_mem_a3", a3, 12);
        chk("rd_mem_wd3", wd3, 32'hCC);
        tick();
        chk("rd_final_we3", we3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
